sdram_arb_rr: RTL

Parametrised successor to the single-port SDRAM arbitrator in the JPEG2000 SDRAM controller. It arbitrates refresh against NCH independent burst requesters. Each requester supplies its own write/read direction. Round-robin fairness is applied among channels. Refresh demand is tracked as a debt counter, so refreshes can be postponed during traffic and forced when urgent. It sits between the tile/FIFO front-ends and the SDRAM command/address generator, which consumes the grant, busy and start strobes.

---
 rtl/sdram_arb_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sdram_arb_rr.sv
// Refresh-vs-burst arbiter for NCH SDRAM requesters: round-robin among channels,
// refresh tracked as a saturating debt, postponed under traffic and forced when urgent.
module sdram_arb_rr #(
  parameter int NCH         = 4,
  parameter int INIT_CYCLES = 35,
  parameter int REF_CYCLE   = 450,
  parameter int REF_LEN     = 2,
  parameter int WR_LEN      = 28,
  parameter int RD_LEN      = 25,
  parameter int MAX_PEND    = 8,
  parameter int URGENT_PEND = 4,
  localparam int XLEN_MAX   = (WR_LEN > RD_LEN) ? WR_LEN : RD_LEN,
  localparam int LEN_MAX    = (XLEN_MAX > REF_LEN) ? XLEN_MAX : REF_LEN,
  localparam int CW         = $clog2(LEN_MAX + 1),
  localparam int PW         = $clog2(MAX_PEND + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] req_wr,
  output logic [NCH-1:0] gnt,
  output logic           xfer_wr,
  output logic           xfer_start,
  output logic           xfer_busy,
  output logic [CW-1:0]  xfer_cnt,
  output logic           ref_start,
  output logic           ref_busy,
  output logic [PW-1:0]  ref_pend,
  output logic           init_done
);

  localparam int IW  = $clog2(NCH);
  localparam int INW = $clog2(INIT_CYCLES + 1);
  localparam int TW  = $clog2(REF_CYCLE + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_REF, S_REF_END, S_XFER, S_XFER_END
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q;
  logic            xfer_wr_q;
  logic [INW-1:0]  init_cnt_q;
  logic [TW-1:0]   ref_tmr_q;
  logic [PW-1:0]   ref_pend_q;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            go_ref, go_xfer;
  logic            tmr_wrap;
  logic [CW-1:0]   xfer_len;

  assign xfer_len = xfer_wr_q ? CW'(WR_LEN) : CW'(RD_LEN);
  assign tmr_wrap = (state_q != S_INIT) && (ref_tmr_q == TW'(REF_CYCLE - 1));

  // Scan downward so the channel nearest to last+1 is the final assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      int j;
      j = (int'(last_q) + k) % NCH;
      if (req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    go_ref  = 1'b0;
    go_xfer = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INW'(INIT_CYCLES - 1)) state_d = S_IDLE;
      end
      S_IDLE, S_REF_END, S_XFER_END: begin
        if (ref_pend_q >= PW'(URGENT_PEND)) begin
          go_ref  = 1'b1;
          state_d = S_REF;
        end else if (win_vld) begin
          go_xfer = 1'b1;
          state_d = S_XFER;
        end else if (ref_pend_q != '0) begin
          go_ref  = 1'b1;
          state_d = S_REF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (cnt_q == xfer_len - 1'b1) state_d = S_XFER_END;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      S_REF: begin
        if (cnt_q == CW'(REF_LEN - 1)) state_d = S_REF_END;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      last_q    <= IW'(NCH - 1);
      xfer_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go_xfer) begin
        last_q    <= win_idx;
        xfer_wr_q <= req_wr[win_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt_q <= '0;
      ref_tmr_q  <= '0;
      ref_pend_q <= '0;
    end else begin
      if (state_q == S_INIT && init_cnt_q != INW'(INIT_CYCLES - 1))
        init_cnt_q <= init_cnt_q + 1'b1;
      if (state_q != S_INIT)
        ref_tmr_q <= tmr_wrap ? '0 : ref_tmr_q + 1'b1;
      // A wrap and a refresh entry in the same cycle cancel out.
      case ({tmr_wrap, go_ref})
        2'b10:   if (ref_pend_q != PW'(MAX_PEND)) ref_pend_q <= ref_pend_q + 1'b1;
        2'b01:   ref_pend_q <= ref_pend_q - 1'b1;
        default: ref_pend_q <= ref_pend_q;
      endcase
    end
  end

  assign gnt        = (state_q == S_XFER) ? (NCH'(1) << last_q) : '0;
  assign xfer_wr    = xfer_wr_q;
  assign xfer_busy  = (state_q == S_XFER);
  assign xfer_start = (state_q == S_XFER) && (cnt_q == '0);
  assign ref_busy   = (state_q == S_REF);
  assign ref_start  = (state_q == S_REF) && (cnt_q == '0);
  assign xfer_cnt   = cnt_q;
  assign ref_pend   = ref_pend_q;
  assign init_done  = (state_q != S_INIT);

endmodule
